// File: rtl/ddco_sweep_pkg.sv
// Shared types and elaboration helpers for the truth-table sweep stage.
// Holds the FSM state encoding, vector-count helper and parameter legality checks.
package ddco_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StSample,
    StDone
  } sweep_state_e;

  localparam int unsigned SettleMin = 1;
  localparam int unsigned NInMin    = 1;
  localparam int unsigned NInMax    = 6;

  function automatic int unsigned nvec(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  function automatic bit settle_ok(input int unsigned settle);
    return settle >= SettleMin;
  endfunction

  function automatic bit n_in_ok(input int unsigned n_in);
    return (n_in >= NInMin) && (n_in <= NInMax);
  endfunction

endpackage

// File: rtl/sweep_settle_ctr.sv
// HOLD-phase cycle counter: counts up while enabled, flags the last settle cycle.
// Clear and reset both return the count to zero.
module sweep_settle_ctr #(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign term = (cnt_q == LastCnt);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector to a small combinational unit, samples its output after a
// settle period, and compares the captured truth table with one latched at start.
module truth_table_sweeper
  import ddco_sweep_pkg::*;
#(
  parameter  int unsigned N_IN   = 3,
  parameter  int unsigned SETTLE = 2,
  localparam int unsigned NVEC   = nvec(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NVEC-1:0] exp_table,
  output logic [N_IN-1:0] vec_out,
  input  logic            y_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [NVEC-1:0] table_out,
  output logic [N_IN-1:0] fail_idx,
  output logic [N_IN:0]   fail_cnt
);

  if (!settle_ok(SETTLE)) begin : g_settle_chk
    $error("SETTLE must be at least %0d", SettleMin);
  end
  if (!n_in_ok(N_IN)) begin : g_n_in_chk
    $error("N_IN must be within %0d..%0d", NInMin, NInMax);
  end

  localparam logic [N_IN-1:0] LastVec = '1;
  localparam logic [N_IN:0]   NvecCnt = (N_IN + 1)'(NVEC);

  sweep_state_e state_q, state_d;

  logic [N_IN-1:0] vec_q;
  logic [NVEC-1:0] exp_q;
  logic [NVEC-1:0] table_q;
  logic [N_IN-1:0] fail_idx_q;
  logic [N_IN:0]   fail_cnt_q;
  logic            pass_q;

  logic accept, sample, ctr_clr, ctr_en, ctr_term;
  logic last_vec, mismatch;

  assign last_vec = (vec_q == LastVec);
  assign mismatch = sample && (y_in != exp_q[vec_q]);

  sweep_settle_ctr #(
    .SETTLE(SETTLE)
  ) u_settle_ctr (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .en  (ctr_en),
    .term(ctr_term)
  );

  always_ff @(posedge clk) begin : p_state
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : p_next_state
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StHold;
      StHold:   if (ctr_term) state_d = StSample;
      StSample: state_d = last_vec ? StDone : StHold;
      StDone:   if (start) state_d = StHold;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin : p_outputs
    accept  = 1'b0;
    sample  = 1'b0;
    ctr_clr = 1'b0;
    ctr_en  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: accept = start;
      StHold: begin
        busy   = 1'b1;
        ctr_en = !ctr_term;
      end
      StSample: begin
        busy    = 1'b1;
        sample  = 1'b1;
        ctr_clr = 1'b1;
      end
      StDone: begin
        done   = 1'b1;
        accept = start;
      end
      default: ;
    endcase
    if (accept) ctr_clr = 1'b1;
  end

  // Capture and compare; the terminal-vector check precedes the increment so vec never wraps.
  always_ff @(posedge clk) begin : p_datapath
    if (rst) begin
      vec_q      <= '0;
      exp_q      <= '0;
      table_q    <= '0;
      fail_idx_q <= '0;
      fail_cnt_q <= '0;
      pass_q     <= 1'b0;
    end else if (accept) begin
      vec_q      <= '0;
      exp_q      <= exp_table;
      table_q    <= '0;
      fail_idx_q <= '0;
      fail_cnt_q <= '0;
      pass_q     <= 1'b0;
    end else if (sample) begin
      table_q[vec_q] <= y_in;
      if (mismatch) begin
        fail_cnt_q <= fail_cnt_q + 1'b1;
        if (fail_cnt_q == '0) fail_idx_q <= vec_q;
      end
      if (last_vec) begin
        pass_q <= (fail_cnt_q == '0) && !mismatch;
      end else begin
        vec_q <= vec_q + 1'b1;
      end
    end
  end

  assign vec_out   = vec_q;
  assign pass      = pass_q;
  assign table_out = table_q;
  assign fail_idx  = fail_idx_q;
  assign fail_cnt  = fail_cnt_q;

  a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy && done));
  a_cnt_bound:      assert property (@(posedge clk) disable iff (rst) fail_cnt_q <= NvecCnt);

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Self-contained sweep and capture stage for small combinational logic blocks (3-input function units such as simp02).
- Drives every input combination to the unit under test and waits a settle period before sampling its single output.
- Assembles the captured truth table and compares it against an expected table latched at start.
- Reports done / pass / first failing minterm. Used on-board and in benches in place of hand-written stimulus lists.

Parameters:
- N_IN, 3, number of inputs of the unit under test. Legal range 1..6.
- SETTLE, 2, cycles each vector is held before sampling. Minimum 1; 0 is illegal (elaboration error).
- Derived localparam NVEC = 2**N_IN.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; honoured only when not busy.
- exp_table  input  NVEC  expected output; bit k = expected y for input vector k. Latched on accepted start.
- vec_out  output  N_IN  input vector to the unit under test (MSB = a, LSB = c for N_IN=3).
- y_in  input  1  output of the unit under test.
- busy  output  1  high from accepted start until done.
- done  output  1  level; high after sweep completes, held until next accepted start or rst.
- pass  output  1  valid when done: high iff no mismatches.
- table_out  output  NVEC  captured truth table; bit k = y_in sampled for vector k.
- fail_idx  output  N_IN  index of first mismatching vector; 0 if none.
- fail_cnt  output  N_IN+1  number of mismatching vectors (0..NVEC).

Behaviour:
- Reset (rst=1 at an edge):
  - All outputs to 0: vec_out, busy, done, pass, table_out, fail_idx, fail_cnt.
  - FSM to IDLE. Internal vec, settle counter and exp latch to 0.
  - rst overrides start in the same cycle.
  - rst mid-sweep aborts immediately; no partial result is retained.
- FSM states: IDLE, HOLD, SAMPLE, DONE.
- IDLE / DONE with start=1:
  - Latch exp_table; clear table_out, fail_cnt, fail_idx, done, pass.
  - vec=0, cnt=0, busy=1, go to HOLD.
- HOLD:
  - vec_out=vec.
  - If cnt==SETTLE-1, go to SAMPLE; else cnt++.
- SAMPLE:
  - table_out[vec] <= y_in.
  - If y_in != exp_latch[vec]: fail_cnt++; if fail_cnt==0 before this increment, fail_idx <= vec.
  - If vec==NVEC-1: go to DONE, busy=0, done=1, pass=(final fail_cnt==0).
  - Else: vec++, cnt=0, go to HOLD.
- DONE:
  - Outputs held.
  - vec_out holds last vector (NVEC-1).
  - A new start restarts the sweep with no intermediate IDLE cycle.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - done rises on edge NVEC*(SETTLE+1) counted from the edge that accepted start (default 24).
- Input handling during a sweep:
  - start while busy is ignored.
  - exp_table changes after acceptance have no effect.
- y_in is sampled only in SAMPLE. Its value at all other times is don't-care.
- Width rules:
  - vec is N_IN bits; increment never wraps because the terminal check precedes it.
  - fail_cnt has N_IN+1 bits, so a count of NVEC does not overflow.

Decomposition:
- Shared package ddco_sweep_pkg holds:
  - state typedef (IDLE, HOLD, SAMPLE, DONE);
  - function/localparam for NVEC;
  - the SETTLE minimum check.
- One natural sub-module: sweep_settle_ctr, the HOLD-phase cycle counter with clear/enable/terminal flag.
- The FSM and capture/compare logic stay in the top module.

Test Plan:
- Reset check: hold rst 2 cycles with start=1 → all outputs 0, busy stays 0.
- Majority-function unit, exp_table=8'hE8, pulse start → done on edge 24; table_out=8'hE8, pass=1, fail_cnt=0, fail_idx=0; vec_out steps 0..7, each held 3 cycles.
- Same unit, exp_table=8'hEC (bit 2 wrong) → pass=0, fail_cnt=1, fail_idx=2. With exp_table=8'h17 → fail_cnt=8, fail_idx=0.
- Pulse start again at cycle 5 and change exp_table to 8'h00 at cycle 6 → no restart; result still pass=1 with table_out=8'hE8; done at edge 24 of the original sweep.
- Assert rst at edge 10 mid-sweep → all outputs 0 on the next edge. A following start runs a full 24-edge sweep with correct results.
- Instance with SETTLE=1 → done on edge 16; each vector held 2 cycles. Back-to-back start in DONE restarts with vec_out=0 on the following edge.
